// File: rtl/arbitro_vc_rr_pkg.sv
// Shared definitions for the VC round-robin scheduler: FSM encodings, VC count,
// pipeline stage-1 record and pointer helper.
package arbitro_vc_rr_pkg;

    localparam int NUM_VC = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic       vld;
        logic [1:0] src;
    } s1_t;

    function automatic logic [1:0] ptr_after(input logic [1:0] win);
        return win + 2'd1;
    endfunction

endpackage

// File: rtl/arbitro_vc_rr_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr_i (mod 4)
// wins; returns one-hot grant, winner index and an any-request flag.
module rr_select
    import arbitro_vc_rr_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] win_o,
    output logic       any_o
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        win_o = ptr_i;
        any_o = 1'b0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (req_i[ptr_i + 2'(k)]) begin
                win_o = ptr_i + 2'(k);
                any_o = 1'b1;
            end
        end
        gnt_o = any_o ? (4'b0001 << win_o) : 4'b0000;
    end

endmodule

// File: rtl/arbitro_vc_rr.sv
// Round-robin mover from 4 input VC FIFOs to 4 output VC FIFOs, routed by the
// word's top two bits. Optional ARBITRO_PRIO0_EN gives VC0 strict priority.
module arbitro_vc_rr
    import arbitro_vc_rr_pkg::*;
#(
    parameter int DW = 6,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            active_in,
    input  logic [3:0]      emp_I,
    input  logic [4*DW-1:0] data_I,
    input  logic [3:0]      almfull_O,
    output logic [3:0]      pop_I,
    output logic [3:0]      push_O,
    output logic [DW-1:0]   data_out,
    output logic [CW-1:0]   xfer_cnt,
    output logic            arb_idle
);

    logic [1:0]    state_q, state_d;
    logic [1:0]    rr_ptr_q;
    s1_t           s1_q;
    logic          vld_s2_q;
    logic [1:0]    dest_q;
    logic [DW-1:0] data_out_q;
    logic [CW-1:0] cnt_q;

    logic [3:0]    req_rr, rr_gnt;
    logic [1:0]    rr_win, win;
    logic          rr_any, vc0_hit, grant_en, ptr_upd;
    logic [DW-1:0] src_word;

`ifdef ARBITRO_PRIO0_EN
    assign req_rr  = ~emp_I & 4'b1110;
    assign vc0_hit = ~emp_I[0];
`else
    assign req_rr  = ~emp_I;
    assign vc0_hit = 1'b0;
`endif

    rr_select u_sel (
        .req_i (req_rr),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt),
        .win_o (rr_win),
        .any_o (rr_any)
    );

    // Almost-full stalls new grants only; the FIFO margin absorbs in-flight words.
    assign grant_en = (state_q == ST_RUN) && active_in && !(|almfull_O);

    always_comb begin
        pop_I   = 4'b0000;
        win     = rr_win;
        ptr_upd = 1'b0;
        if (grant_en) begin
            if (vc0_hit) begin
                pop_I = 4'b0001;
                win   = 2'd0;
            end else if (rr_any) begin
                pop_I   = rr_gnt;
                ptr_upd = 1'b1;
            end
        end
    end

    // Leave DRAIN once stage 1 is empty: stage 2 retires this cycle, so the
    // pipeline is empty when IDLE is entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (active_in) state_d = ST_RUN;
            ST_RUN:   if (!active_in) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (active_in)      state_d = ST_RUN;
                else if (!s1_q.vld) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign src_word = data_I[32'(s1_q.src) * DW +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 2'd0;
            s1_q       <= '0;
            vld_s2_q   <= 1'b0;
            dest_q     <= 2'd0;
            data_out_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q  <= state_d;
            if (ptr_upd) rr_ptr_q <= ptr_after(win);
            s1_q     <= '{vld: |pop_I, src: win};
            vld_s2_q <= s1_q.vld;
            if (s1_q.vld) begin
                data_out_q <= src_word;
                dest_q     <= src_word[DW-1:DW-2];
            end
            if (vld_s2_q) cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign push_O   = vld_s2_q ? (4'b0001 << dest_q) : 4'b0000;
    assign data_out = data_out_q;
    assign xfer_cnt = cnt_q;
    assign arb_idle = (state_q == ST_IDLE) && !s1_q.vld && !vld_s2_q;

endmodule
